mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped peripheral responder that answers the core's data-memory request/valid handshake, acting as the slave end alongside the data memory. Decodes a word address into a small register file: GPIO output and input, a free-running timer with compare, and a control/status pair. Responds after a configurable number of wait states and drives a level interrupt from the timer.

## Interface

- WAIT_STATES, 1, idle cycles inserted between request capture and the response; 0..15
- GPIO_RESET, 32'h0000_0000, reset value of gpio_out

- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- request  input  1  single-cycle transaction strobe from the core
- we_re  input  1  1 = write, 0 = read
- mask  input  4  byte-lane enables for writes; bit i enables data_in[8i+7:8i]
- address  input  8  word index (byte address bits [9:2])
- data_in  input  32  write data
- valid  output  1  one-cycle response strobe
- data_out  output  32  read data, meaningful only while valid = 1
- gpio_in  input  32  asynchronous external inputs
- gpio_out  output  32  registered GPIO outputs
- irq  output  1  level interrupt, timer match

## Operation

- Register map (word index): 0x00 GPIO_OUT rw; 0x01 GPIO_IN ro; 0x02 TIMER_COUNT rw; 0x03 TIMER_CMP rw; 0x04 CTRL rw (bit0 timer enable, bit1 irq enable, others read 0); 0x05 STATUS (bit0 match flag, write-1-to-clear, others read 0).
- Any other address: reads return 0, writes dropped, valid still returned.
- FSM: IDLE → WAIT (when WAIT_STATES > 0) → RESP → IDLE. IDLE with request = 1 captures we_re, mask, address, data_in; goes to WAIT, or to RESP directly when WAIT_STATES = 0. WAIT counts down WAIT_STATES cycles. RESP lasts exactly one cycle.
- request is sampled only in IDLE; strobes arriving in WAIT or RESP are ignored (not queued).
- Writes commit on the clock edge that ends RESP, honouring mask per byte lane; read-only registers ignore writes. mask = 0 makes a write a no-op that still returns valid.
- Read data is selected from register values at the clock edge entering RESP.
- gpio_in passes through a two-flop synchronizer before GPIO_IN.
- Timer: with CTRL.bit0 = 1, TIMER_COUNT increments by 1 per cycle, wrapping 0xFFFF_FFFF → 0. A bus write to TIMER_COUNT overrides the increment in that cycle.
- Match: in any cycle with CTRL.bit0 = 1 and TIMER_COUNT == TIMER_CMP, STATUS.bit0 is set on the next edge and is sticky. If a set and a write-1-clear coincide, set wins.
- irq = STATUS.bit0 & CTRL.bit1, registered.

## Timing

- Latency: request in cycle N → valid = 1 in cycle N+1+WAIT_STATES; the earliest next accepted request is cycle N+2+WAIT_STATES.
- valid is high for exactly one cycle per accepted request; data_out = 0 whenever valid = 0, and for writes.
- GPIO_IN reflects gpio_in 2 cycles after a change, plus the response latency.
- gpio_out updates in the cycle after valid for a GPIO_OUT write.
- Reset values: valid 0, data_out 0, gpio_out GPIO_RESET, irq 0, TIMER_COUNT 0, TIMER_CMP 0xFFFF_FFFF, CTRL 0, STATUS 0, FSM IDLE, synchronizer 0.
- Reset during WAIT or RESP aborts the transaction: no valid pulse and no write commit.

## Configuration

- MMIO_TIMER_EN defined: timer, TIMER_COUNT, TIMER_CMP, CTRL, STATUS and irq are implemented as specified.
- MMIO_TIMER_EN undefined: addresses 0x02–0x05 behave as unmapped (read 0, writes dropped), irq is tied to 0, and no timer flops are synthesized. The handshake and GPIO are unchanged.

## Structure

- Package mmio_pkg: register word-index localparams (REG_GPIO_OUT … REG_STATUS), CTRL/STATUS bit-position constants, FSM state enum type.
- Sub-module mmio_timer (compiled only under MMIO_TIMER_EN) owns the count, compare, flag and irq logic, with write-enable/byte-mask inputs from the responder.
- Top-level mmio_responder holds the FSM, capture registers, wait counter, address decode, GPIO registers and synchronizer.

## Test plan

- Reset, then write 0xDEAD_BEEF to 0x00 with mask 4'b1111 → valid at N+2 (WAIT_STATES = 1); gpio_out = 0xDEAD_BEEF the next cycle; read of 0x00 returns 0xDEAD_BEEF.
- Write 0x1122_3344 to 0x00 with mask 4'b0101 over 0xDEAD_BEEF → gpio_out = 0xDE22_BE44.
- Drive gpio_in = 0x0000_00A5, wait 3 cycles, read 0x01 → 0x0000_00A5; read 0x3F → 0 with valid; a request pulsed during WAIT is ignored, giving one valid only.
- Write TIMER_CMP = 10, CTRL = 0x3, TIMER_COUNT = 0 → irq rises one cycle after count reaches 10; write STATUS = 1 → irq falls; count = 0xFFFF_FFFF wraps to 0.
- Timer match occurring in the same cycle as a STATUS write-1-clear → flag remains 1.
- Assert rst during WAIT of a write to 0x00 → no valid, gpio_out = GPIO_RESET; build without MMIO_TIMER_EN → read 0x02 returns 0, irq remains 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register word indices, CTRL/STATUS
// bit positions, FSM state type and a byte-lane merge helper.
package mmio_pkg;

  localparam logic [7:0] REG_GPIO_OUT    = 8'h00;
  localparam logic [7:0] REG_GPIO_IN     = 8'h01;
  localparam logic [7:0] REG_TIMER_COUNT = 8'h02;
  localparam logic [7:0] REG_TIMER_CMP   = 8'h03;
  localparam logic [7:0] REG_CTRL        = 8'h04;
  localparam logic [7:0] REG_STATUS      = 8'h05;

  localparam int CTRL_TIMER_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STATUS_MATCH_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Replace the byte lanes of old_val selected by lane_mask with wdata.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  lane_mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running timer with compare, sticky match flag and level irq.
// Only instantiated when MMIO_TIMER_EN is defined.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic        status_we,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [1:0]  ctrl,
  output logic        flag,
  output logic        irq
);

  logic [31:0] count_r;
  logic [31:0] cmp_r;
  logic [1:0]  ctrl_r;
  logic        flag_r;
  logic        irq_r;
  logic [1:0]  ctrl_next_s;
  logic        flag_next_s;
  logic        match_s;
  logic        clear_s;

  // Next CTRL and flag values; a match in the same cycle as a clear keeps the flag set
  always_comb begin
    if (ctrl_we && wmask[0]) ctrl_next_s = wdata[1:0];
    else                     ctrl_next_s = ctrl_r;
    match_s = ctrl_r[CTRL_TIMER_EN_BIT] && (count_r == cmp_r);
    clear_s = status_we && wmask[0] && wdata[STATUS_MATCH_BIT];
    if (match_s)      flag_next_s = 1'b1;
    else if (clear_s) flag_next_s = 1'b0;
    else              flag_next_s = flag_r;
  end

  // Timer state; irq is registered from the next flag/enable so it tracks them exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 32'd0;
      cmp_r   <= 32'hFFFF_FFFF;
      ctrl_r  <= 2'b00;
      flag_r  <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      if (count_we)                         count_r <= byte_merge(count_r, wdata, wmask);
      else if (ctrl_r[CTRL_TIMER_EN_BIT])   count_r <= count_r + 32'd1;
      if (cmp_we) cmp_r <= byte_merge(cmp_r, wdata, wmask);
      ctrl_r <= ctrl_next_s;
      flag_r <= flag_next_s;
      irq_r  <= flag_next_s & ctrl_next_s[CTRL_IRQ_EN_BIT];
    end
  end

  assign count = count_r;
  assign cmp   = cmp_r;
  assign ctrl  = ctrl_r;
  assign flag  = flag_r;
  assign irq   = irq_r;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: request/valid handshake with wait states, GPIO and
// an optional timer block enabled by defining MMIO_TIMER_EN.
module mmio_responder #(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] GPIO_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [7:0]  address,
  input  logic [31:0] data_in,
  output logic        valid,
  output logic [31:0] data_out,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq
);
  import mmio_pkg::*;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  wait_cnt_r;
  logic        cap_we_r;
  logic [3:0]  cap_mask_r;
  logic [7:0]  cap_addr_r;
  logic [31:0] cap_data_r;
  logic [31:0] gpio_out_r;
  logic [31:0] sync1_r;
  logic [31:0] sync2_r;
  logic        valid_r;
  logic [31:0] data_out_r;
  logic [7:0]  addr_sel_s;
  logic        we_sel_s;
  logic [31:0] rdata_s;
  logic        enter_resp_s;
  logic        commit_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (request) begin
          if (WAIT_STATES > 0) state_next_s = ST_WAIT;
          else                 state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) state_next_s = ST_RESP;
        else                    state_next_s = ST_WAIT;
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: response launch and write commit strobes
  always_comb begin
    enter_resp_s = (state_next_s == ST_RESP);
    commit_s     = (state_r == ST_RESP) && cap_we_r && (cap_mask_r != 4'b0000);
  end

  // With zero wait states the edge entering RESP is also the capture edge
  always_comb begin
    if (state_r == ST_IDLE) begin
      addr_sel_s = address;
      we_sel_s   = we_re;
    end else begin
      addr_sel_s = cap_addr_r;
      we_sel_s   = cap_we_r;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] tmr_count_s;
  logic [31:0] tmr_cmp_s;
  logic [1:0]  tmr_ctrl_s;
  logic        tmr_flag_s;
  logic        tmr_irq_s;

  mmio_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .count_we  (commit_s && (cap_addr_r == REG_TIMER_COUNT)),
    .cmp_we    (commit_s && (cap_addr_r == REG_TIMER_CMP)),
    .ctrl_we   (commit_s && (cap_addr_r == REG_CTRL)),
    .status_we (commit_s && (cap_addr_r == REG_STATUS)),
    .wmask     (cap_mask_r),
    .wdata     (cap_data_r),
    .count     (tmr_count_s),
    .cmp       (tmr_cmp_s),
    .ctrl      (tmr_ctrl_s),
    .flag      (tmr_flag_s),
    .irq       (tmr_irq_s)
  );

  assign irq = tmr_irq_s;
`else
  assign irq = 1'b0;
`endif

  // Read data mux over the register map; unmapped words read as zero
  always_comb begin
    rdata_s = 32'd0;
    case (addr_sel_s)
      REG_GPIO_OUT:    rdata_s = gpio_out_r;
      REG_GPIO_IN:     rdata_s = sync2_r;
`ifdef MMIO_TIMER_EN
      REG_TIMER_COUNT: rdata_s = tmr_count_s;
      REG_TIMER_CMP:   rdata_s = tmr_cmp_s;
      REG_CTRL:        rdata_s = {30'd0, tmr_ctrl_s};
      REG_STATUS:      rdata_s = {31'd0, tmr_flag_s};
`endif
      default:         rdata_s = 32'd0;
    endcase
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we_r   <= 1'b0;
      cap_mask_r <= 4'b0000;
      cap_addr_r <= 8'd0;
      cap_data_r <= 32'd0;
      wait_cnt_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && request) begin
      cap_we_r   <= we_re;
      cap_mask_r <= mask;
      cap_addr_r <= address;
      cap_data_r <= data_in;
      wait_cnt_r <= WAIT_LOAD;
    end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
      wait_cnt_r <= wait_cnt_r - 4'd1;
    end
  end

  // Registered response; data_out is zero outside the valid cycle and for writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= 1'b0;
      data_out_r <= 32'd0;
    end else begin
      valid_r    <= enter_resp_s;
      data_out_r <= (enter_resp_s && !we_sel_s) ? rdata_s : 32'd0;
    end
  end

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_r <= GPIO_RESET;
      sync1_r    <= 32'd0;
      sync2_r    <= 32'd0;
    end else begin
      if (commit_s && (cap_addr_r == REG_GPIO_OUT))
        gpio_out_r <= byte_merge(gpio_out_r, cap_data_r, cap_mask_r);
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
    end
  end

  assign valid    = valid_r;
  assign data_out = data_out_r;
  assign gpio_out = gpio_out_r;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder; timer checks compile in when
// MMIO_TIMER_EN is defined, otherwise the timer window is checked as unmapped.
`timescale 1ns/1ps
module tb_mmio_responder;

  localparam int          WS   = 1;
  localparam logic [31:0] GRST = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst, request, we_re, valid, irq;
  logic [3:0]  mask;
  logic [7:0]  address;
  logic [31:0] data_in, data_out, gpio_in, gpio_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] gpio_m;

  mmio_responder #(.WAIT_STATES(WS), .GPIO_RESET(GRST)) dut (
    .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
    .address(address), .data_in(data_in), .valid(valid), .data_out(data_out),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference byte-lane update: each enabled lane takes the new byte.
  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] m);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = m[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One bus transaction; returns read data and the cycle in which valid was seen.
  task automatic txn(input logic w, input logic [3:0] m, input logic [7:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output int vcyc);
    int c0;
    bit seen;
    @(negedge clk);
    c0 = cyc;
    request = 1'b1; we_re = w; mask = m; address = a; data_in = d;
    @(negedge clk);
    request = 1'b0;
    seen = 1'b0; rd = 32'd0; vcyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (valid) begin
        seen = 1'b1; rd = data_out; vcyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check32("valid_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check32("latency", 32'(vcyc - c0), 32'(WS + 1));
      if (w) check32("wr_data_out", rd, 32'd0);
      @(negedge clk);
      check32("valid_one_cycle", {31'd0, valid}, 32'd0);
      check32("data_out_idle", data_out, 32'd0);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m, output int vcyc);
    logic [31:0] rd;
    txn(1'b1, m, a, d, rd, vcyc);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int v;
    txn(1'b0, 4'hF, a, 32'd0, rd, v);
    check32(tag, rd, exp);
  endtask

  initial begin
    int v, nv, e, ez;
    logic [31:0] rd, d, exp;
    logic [7:0] a;
    logic [3:0] m;
    logic w;

    rst = 1'b1; request = 1'b0; we_re = 1'b0; mask = 4'h0;
    address = 8'd0; data_in = 32'd0; gpio_in = 32'd0;
    repeat (3) @(negedge clk);
    check32("rst_valid", {31'd0, valid}, 32'd0);
    check32("rst_data_out", data_out, 32'd0);
    check32("rst_gpio_out", gpio_out, GRST);
    check32("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    gpio_m = GRST;

    // GPIO_OUT writes with full and partial lanes
    wr(8'h00, 32'hDEAD_BEEF, 4'hF, v);
    check32("gpio_full", gpio_out, 32'hDEAD_BEEF);
    rd_chk("rd_gpio_out", 8'h00, 32'hDEAD_BEEF);
    wr(8'h00, 32'h1122_3344, 4'b0101, v);
    check32("gpio_lanes", gpio_out, 32'hDE22_BE44);
    wr(8'h00, 32'hFFFF_FFFF, 4'b0000, v);
    check32("gpio_mask0", gpio_out, 32'hDE22_BE44);
    wr(8'h01, 32'hFFFF_FFFF, 4'hF, v);
    check32("gpio_in_ro", gpio_out, 32'hDE22_BE44);
    gpio_m = 32'hDE22_BE44;

    gpio_in = 32'h0000_00A5;
    repeat (3) @(negedge clk);
    rd_chk("rd_gpio_in", 8'h01, 32'h0000_00A5);
    rd_chk("rd_unmapped", 8'h3F, 32'd0);

    // A second strobe while the first is in WAIT must not be queued
    @(negedge clk);
    request = 1'b1; we_re = 1'b0; address = 8'h00; mask = 4'hF;
    @(negedge clk);
    @(negedge clk);
    request = 1'b0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      nv += int'(valid);
      @(negedge clk);
    end
    check32("ignored_request", 32'(nv), 32'd1);

`ifdef MMIO_TIMER_EN
    rd_chk("cmp_reset", 8'h03, 32'hFFFF_FFFF);
    rd_chk("count_reset", 8'h02, 32'd0);
    wr(8'h03, 32'd10, 4'hF, v);
    wr(8'h02, 32'd0, 4'hF, v);
    wr(8'h04, 32'h0000_0003, 4'hF, v);
    e = v + 1;                                  // counting starts after this edge
    txn(1'b0, 4'hF, 8'h02, 32'd0, rd, v);
    check32("count_run", rd, 32'(v - 1 - e));
    while (cyc < e + 10) @(negedge clk);
    check32("irq_before_match", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check32("irq_after_match", {31'd0, irq}, 32'd1);
    rd_chk("status_set", 8'h05, 32'd1);
    rd_chk("ctrl_rd", 8'h04, 32'd3);
    wr(8'h05, 32'd1, 4'hF, v);
    check32("irq_cleared", {31'd0, irq}, 32'd0);
    wr(8'h03, 32'd1000, 4'hF, v);
    wr(8'h02, 32'hFFFF_FFFF, 4'hF, v);
    e = v + 1;
    txn(1'b0, 4'hF, 8'h02, 32'd0, rd, v);
    check32("count_wrap", rd, 32'(v - 1 - e) + 32'hFFFF_FFFF);
    wr(8'h02, 32'd0, 4'hF, v);
    ez = v + 1;
    wr(8'h03, 32'd40, 4'hF, v);
    rd_chk("status_clear", 8'h05, 32'd0);
    // Time the clear commit to the very edge at which the match sets the flag
    while (cyc < ez + 40 - WS - 2) @(negedge clk);
    wr(8'h05, 32'd1, 4'hF, v);
    rd_chk("set_beats_clear", 8'h05, 32'd1);
    check32("irq_set_beats_clear", {31'd0, irq}, 32'd1);
    wr(8'h04, 32'h0000_0001, 4'hF, v);
    check32("irq_disabled", {31'd0, irq}, 32'd0);
`else
    wr(8'h04, 32'h0000_0003, 4'hF, v);
    repeat (5) @(negedge clk);
    rd_chk("notimer_count", 8'h02, 32'd0);
    rd_chk("notimer_ctrl", 8'h04, 32'd0);
    rd_chk("notimer_status", 8'h05, 32'd0);
    check32("notimer_irq", {31'd0, irq}, 32'd0);
`endif

    // Reset in the middle of a GPIO write aborts it
    @(negedge clk);
    request = 1'b1; we_re = 1'b1; mask = 4'hF; address = 8'h00; data_in = 32'h1234_5678;
    @(negedge clk);
    request = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      nv += int'(valid);
      @(negedge clk);
    end
    check32("abort_no_valid", 32'(nv), 32'd0);
    check32("abort_gpio", gpio_out, GRST);
    check32("abort_irq", {31'd0, irq}, 32'd0);
    gpio_m = GRST;

    // Randomized GPIO / unmapped traffic against the register model
    for (int n = 0; n < 40; n++) begin
      gpio_in = $urandom;
      repeat (3) @(negedge clk);
      case ($urandom_range(0, 3))
        0: a = 8'h00;
        1: a = 8'h01;
        2: a = 8'($urandom_range(6, 255));
`ifdef MMIO_TIMER_EN
        default: a = 8'h00;
`else
        default: a = 8'($urandom_range(2, 5));
`endif
      endcase
      w = 1'($urandom_range(0, 1));
      m = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 8'h00)      exp = gpio_m;
      else if (a == 8'h01) exp = gpio_in;
      else                 exp = 32'd0;
      txn(w, m, a, d, rd, v);
      if (w) begin
        if (a == 8'h00) gpio_m = lanes(gpio_m, d, m);
        check32("rand_gpio_out", gpio_out, gpio_m);
      end else begin
        check32("rand_read", rd, exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
